snoop_mem_responder: RTL
========================

Name: snoop_mem_responder

Overview:
- Shared-memory end of the 10-bit snooping bus used by the MESI CPU caches.
- Watches bus requests broadcast by an initiating CPU.
- Supplies the block from main memory on a read or write miss when no other cache claims it via the shared line.
- Absorbs write-back data that caches place on the bus. Sits on the bus alongside the CPUs; one instance per system.

Parameters:
- ADDR_W, 3, tag/address width; memory depth 2**ADDR_W.
- DATA_W, 3, data width per word.
- SNOOP_WAIT, 2, cycles waited after request capture before sampling shared_in (1..3).
- HOLD_CYCLES, 2, cycles the response stays driven on bus_out (1..3).

Ports:
- clock  in  1  system clock, rising edge.
- clear  in  1  synchronous, active-low reset.
- habilita  in  1  enable; when 0 all state, memory and outputs hold.
- bus_in  in  10  bus word: [9:8] bus op, [7:6] memory msg, [5:3] tag/address, [2:0] data.
- shared_in  in  1  OR of all caches' shared_out.
- bus_out  out  10  response word, same field layout as bus_in.
- busy  out  1  high while a request is being serviced.
- out  out  3  last data word read from or written to memory.

Behaviour:
- Encodings, bus op: 00 none, 01 read miss, 10 write miss, 11 invalidate.
- Encodings, memory msg: 00 none, 01 memory supplies data, 10 cache write-back.
- Reset (clear==0 at posedge): state IDLE, bus_out=0, busy=0, out=0, counters 0, mem[i]=i[DATA_W-1:0] for all i. Reset mid-transaction aborts it with no memory write.
- All actions below require habilita==1; otherwise everything holds, including the SNOOP/HOLD counters.
- FSM states: IDLE, SNOOP, DECIDE, DRIVE, DONE.
- IDLE: if bus_in[9:8] is 01 or 10 and bus_in[7:6]==00, latch addr=bus_in[5:3] and op, set busy=1, load wait counter with SNOOP_WAIT-1, go to SNOOP. Op 11 or 00 is ignored.
- SNOOP: decrement the wait counter; at 0 go to DECIDE.
- DECIDE: sample shared_in.
  - shared_in=1: a cache supplies data, memory stays silent; go to DONE.
  - shared_in=0: bus_out <= {2'b00, 2'b01, addr, mem[addr]}, out <= mem[addr], load hold counter with HOLD_CYCLES-1, go to DRIVE.
- DRIVE: bus_out is held constant; decrement the hold counter; at 0 clear bus_out to 0 and go to DONE.
- DONE: busy=0, go to IDLE. A new request can be accepted on the next cycle. Total latency from request capture to first response cycle is SNOOP_WAIT+1 clocks.
- Write-back: in any state, bus_in[7:6]==10 writes mem[bus_in[5:3]] <= bus_in[2:0] and sets out <= bus_in[2:0]. The write takes effect in the same cycle, independent of the FSM.
- Forwarding: a write-back in the DECIDE cycle to the latched addr makes the response carry the write-back data, never the stale word.
- A write-back in DRIVE does not alter the word already being driven.
- Requests arriving while busy=1 are dropped; the bus protocol guarantees serialized transactions.
- Address wraps modulo 2**ADDR_W. No arithmetic overflow is possible.

Optional Feature:
- Macro: SNOOP_MEM_STATS_EN.
- When defined: adds outputs rd_served (8 bits), cache_fwd (8 bits) and wb_count (8 bits).
  - rd_served increments on each DECIDE with shared_in=0.
  - cache_fwd increments on each DECIDE with shared_in=1.
  - wb_count increments on each write-back.
  - All three saturate at 255 and are cleared by reset.
- When undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then read miss with tag 101 and shared_in=0 throughout -> bus_out=10'b00_01_101_101 on cycles 4 and 5 after capture, then 0; busy high for 6 cycles.
- Read miss with tag 010 and shared_in=1 asserted in the DECIDE cycle -> bus_out stays 0, busy drops after DONE, mem unchanged.
- Write-back {00,10,011,110}, then read miss tag 011 with shared_in=0 -> response data 110, out=110.
- Read miss tag 100 plus a write-back to tag 100 with data 111 exactly in the DECIDE cycle -> response data 111 (forwarded).
- habilita=0 for 3 cycles during SNOOP -> response delayed by exactly 3 cycles, with the same content.
- clear=0 during DRIVE -> next cycle bus_out=0, busy=0, mem[6]=110 (reinitialized); with SNOOP_MEM_STATS_EN defined, all counters read 0.

Source files
------------

// File: rtl/snoop_mem_responder.sv
// Shared-memory responder on the MESI snooping bus: supplies blocks on misses and absorbs write-backs.
// Optional statistics counters are enabled by defining SNOOP_MEM_STATS_EN.
module snoop_mem_responder #(
  parameter int unsigned ADDR_W      = 3,
  parameter int unsigned DATA_W      = 3,
  parameter int unsigned SNOOP_WAIT  = 2,
  parameter int unsigned HOLD_CYCLES = 2,
  localparam int unsigned BUS_W      = 4 + ADDR_W + DATA_W
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              habilita,
  input  logic [BUS_W-1:0]  bus_in,
  input  logic              shared_in,
  output logic [BUS_W-1:0]  bus_out,
  output logic              busy,
  output logic [DATA_W-1:0] out
`ifdef SNOOP_MEM_STATS_EN
  ,
  output logic [7:0]        rd_served,
  output logic [7:0]        cache_fwd,
  output logic [7:0]        wb_count
`endif
);

  localparam int unsigned Depth     = 1 << ADDR_W;
  localparam logic [1:0]  SnoopLoad = 2'(SNOOP_WAIT - 1);
  localparam logic [1:0]  HoldLoad  = 2'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StSnoop, StDecide, StDrive, StDone} state_e;

  state_e              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
  logic [1:0]          r_cnt, w_cnt_nxt;
  logic [BUS_W-1:0]    r_bus_out, w_bus_out_nxt;
  logic                r_busy, w_busy_nxt;
  logic [DATA_W-1:0]   r_out, w_out_nxt;
  logic [DATA_W-1:0]   r_mem [Depth];

  logic [1:0]          w_op, w_msg;
  logic [ADDR_W-1:0]   w_bus_addr;
  logic [DATA_W-1:0]   w_bus_data, w_rd_data;
  logic                w_req, w_wb, w_cnt_zero, w_fwd;

  assign w_op       = bus_in[BUS_W-1 -: 2];
  assign w_msg      = bus_in[BUS_W-3 -: 2];
  assign w_bus_addr = bus_in[DATA_W +: ADDR_W];
  assign w_bus_data = bus_in[DATA_W-1:0];
  assign w_req      = (w_op == 2'b01 || w_op == 2'b10) && (w_msg == 2'b00);
  assign w_wb       = (w_msg == 2'b10);
  assign w_cnt_zero = (r_cnt == 2'd0);
  // A write-back to the block being answered this cycle must win over the stale word.
  assign w_fwd      = w_wb && (w_bus_addr == r_addr);
  assign w_rd_data  = w_fwd ? w_bus_data : r_mem[r_addr];

  always_ff @(posedge clock) begin
    if (!clear) begin
      r_state <= StIdle;
    end else if (habilita) begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle:   if (w_req) w_state_nxt = StSnoop;
      StSnoop:  if (w_cnt_zero) w_state_nxt = StDecide;
      StDecide: w_state_nxt = shared_in ? StDone : StDrive;
      StDrive:  if (w_cnt_zero) w_state_nxt = StDone;
      StDone:   w_state_nxt = StIdle;
      default:  w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    w_addr_nxt    = r_addr;
    w_cnt_nxt     = r_cnt;
    w_bus_out_nxt = r_bus_out;
    w_busy_nxt    = r_busy;
    w_out_nxt     = r_out;
    case (r_state)
      StIdle: begin
        if (w_req) begin
          w_addr_nxt = w_bus_addr;
          w_busy_nxt = 1'b1;
          w_cnt_nxt  = SnoopLoad;
        end
      end
      StSnoop: begin
        if (!w_cnt_zero) w_cnt_nxt = r_cnt - 2'd1;
      end
      StDecide: begin
        if (!shared_in) begin
          w_bus_out_nxt = {2'b00, 2'b01, r_addr, w_rd_data};
          w_out_nxt     = w_rd_data;
          w_cnt_nxt     = HoldLoad;
        end
      end
      StDrive: begin
        if (w_cnt_zero) w_bus_out_nxt = '0;
        else            w_cnt_nxt     = r_cnt - 2'd1;
      end
      StDone: begin
        w_busy_nxt = 1'b0;
      end
      default: ;
    endcase
    if (w_wb) w_out_nxt = w_bus_data;
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      r_addr    <= '0;
      r_cnt     <= '0;
      r_bus_out <= '0;
      r_busy    <= 1'b0;
      r_out     <= '0;
      for (int i = 0; i < Depth; i++) r_mem[i] <= DATA_W'(i);
    end else if (habilita) begin
      r_addr    <= w_addr_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bus_out <= w_bus_out_nxt;
      r_busy    <= w_busy_nxt;
      r_out     <= w_out_nxt;
      if (w_wb) r_mem[w_bus_addr] <= w_bus_data;
    end
  end

  assign bus_out = r_bus_out;
  assign busy    = r_busy;
  assign out     = r_out;

`ifdef SNOOP_MEM_STATS_EN
  logic [7:0] r_rd_served, r_cache_fwd, r_wb_count;
  logic       w_decide;

  assign w_decide = (r_state == StDecide);

  always_ff @(posedge clock) begin
    if (!clear) begin
      r_rd_served <= '0;
      r_cache_fwd <= '0;
      r_wb_count  <= '0;
    end else if (habilita) begin
      if (w_decide && !shared_in && r_rd_served != 8'hff) r_rd_served <= r_rd_served + 8'd1;
      if (w_decide && shared_in && r_cache_fwd != 8'hff)  r_cache_fwd <= r_cache_fwd + 8'd1;
      if (w_wb && r_wb_count != 8'hff)                    r_wb_count  <= r_wb_count + 8'd1;
    end
  end

  assign rd_served = r_rd_served;
  assign cache_fwd = r_cache_fwd;
  assign wb_count  = r_wb_count;
`endif

endmodule
